// File: rtl/mips_imem_loader_if.sv
// mips_imem_loader_if
//   Bundles the loader's two data paths: the incoming byte stream
//   (valid/ready handshake) and the write port into InstructionMemory.
//   master : the loader itself (consumes bytes, drives memory writes)
//   slave  : the surrounding environment (byte source + instruction memory)
// Signals
//   byte_in_valid  source presents byte_in_data
//   byte_in_data   stream byte, MSB-first within each word
//   byte_in_ready  loader accepts a byte this cycle
//   imem_wr_en     one-cycle write strobe
//   imem_wr_addr   word-aligned byte address of the write
//   imem_wr_data   instruction word being written
interface mips_imem_loader_if #(
  parameter int ADDR_W = 32
);
  logic              byte_in_valid;
  logic [7:0]        byte_in_data;
  logic              byte_in_ready;
  logic              imem_wr_en;
  logic [ADDR_W-1:0] imem_wr_addr;
  logic [31:0]       imem_wr_data;

  modport master (
    input  byte_in_valid,
    input  byte_in_data,
    output byte_in_ready,
    output imem_wr_en,
    output imem_wr_addr,
    output imem_wr_data
  );

  modport slave (
    output byte_in_valid,
    output byte_in_data,
    input  byte_in_ready,
    input  imem_wr_en,
    input  imem_wr_addr,
    input  imem_wr_data
  );
endinterface

// File: rtl/mips_imem_loader.sv
// mips_imem_loader
//   Fills InstructionMemory from a byte stream. The stream starts with a
//   4-byte big-endian word count N, followed by N big-endian instructions.
//   Each assembled word is written at BASE_ADDR + 4*i in a single-cycle
//   WRITE state. The core is held off fetch until the image is complete.
// Ports
//   clk        core clock, rising edge
//   rst        synchronous reset, active low
//   bus        mips_imem_loader_if.master (byte stream in, imem write out)
//   reload     pulse in DONE to accept a fresh image
//   core_hold  1 while the core must not fetch
//   load_done  level, image fully written
//   load_err   level, header count exceeded IMEM_DEPTH (cleared by reset)
//   word_cnt   words written in the current load
module mips_imem_loader #(
  parameter int IMEM_DEPTH = 256,
  parameter int BASE_ADDR  = 0,
  parameter int ADDR_W     = 32
) (
  input  logic                clk,
  input  logic                rst,
  mips_imem_loader_if.master  bus,
  input  logic                reload,
  output logic                core_hold,
  output logic                load_done,
  output logic                load_err,
  output logic [31:0]         word_cnt
);

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    DATA,
    WRITE,
    DONE,
    ERR
  } loadState_e;

  localparam logic [ADDR_W-1:0] BaseAddr = ADDR_W'(BASE_ADDR);
  localparam logic [31:0]       Depth    = 32'(IMEM_DEPTH);

  loadState_e  state;
  loadState_e  nextState;
  logic [1:0]  byteIdx;
  logic [31:0] hdrCount;
  logic [31:0] asmWord;
  logic [31:0] wordCnt;

  logic        byteTake;
  logic        lastByte;
  logic [31:0] newHdr;
  logic [31:0] wordCntNext;

  assign byteTake    = bus.byte_in_valid & bus.byte_in_ready;
  assign lastByte    = byteTake && (byteIdx == 2'd3);
  // Header value as it will be once the byte on the bus is shifted in;
  // lets the FSM decide the exit on the edge that takes the 4th byte.
  assign newHdr      = {hdrCount[23:0], bus.byte_in_data};
  assign wordCntNext = wordCnt + 32'd1;

  // State register. Reset always wins, whatever the inputs are doing.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // Next-state decode. WRITE lasts exactly one cycle; hdrCount already
  // holds the full N by the time any WRITE state is reached.
  always_comb begin
    nextState = state;
    case (state)
      IDLE:  nextState = HDR;
      HDR: begin
        if (lastByte) begin
          if (newHdr == 32'd0) begin
            nextState = DONE;
          end else if (newHdr > Depth) begin
            nextState = ERR;
          end else begin
            nextState = DATA;
          end
        end
      end
      DATA: begin
        if (lastByte) begin
          nextState = WRITE;
        end
      end
      WRITE: nextState = (wordCntNext == hdrCount) ? DONE : DATA;
      DONE: begin
        if (reload) begin
          nextState = HDR;
        end
      end
      ERR:     nextState = ERR;
      default: nextState = IDLE;
    endcase
  end

  // Byte assembly and word counting. byteIdx wraps naturally after the
  // 4th byte, so each header/word always starts at index 0. A reset in
  // the middle of a word clears byteIdx, so stale bytes never combine
  // with a new stream; the assembly register is fully refilled anyway.
  always_ff @(posedge clk) begin
    if (!rst) begin
      byteIdx  <= 2'd0;
      hdrCount <= 32'd0;
      asmWord  <= 32'd0;
      wordCnt  <= 32'd0;
    end else begin
      if (byteTake) begin
        byteIdx <= byteIdx + 2'd1;
      end
      if (byteTake && state == HDR) begin
        hdrCount <= newHdr;
      end
      if (byteTake && state == DATA) begin
        asmWord <= {asmWord[23:0], bus.byte_in_data};
      end
      if (state == HDR && lastByte) begin
        wordCnt <= 32'd0;
      end
      if (state == WRITE) begin
        wordCnt <= wordCntNext;
      end
      if (state == DONE && reload) begin
        wordCnt <= 32'd0;
        byteIdx <= 2'd0;
      end
    end
  end

  // Outputs are pure decodes of the registered state and datapath. The
  // write address is derived from wordCnt so it reads BASE_ADDR in reset
  // and wraps silently at ADDR_W bits.
  assign bus.byte_in_ready = (state == HDR) || (state == DATA);
  assign bus.imem_wr_en    = (state == WRITE);
  assign bus.imem_wr_addr  = BaseAddr + ADDR_W'({wordCnt[29:0], 2'b00});
  assign bus.imem_wr_data  = asmWord;
  assign core_hold         = (state != DONE);
  assign load_done         = (state == DONE);
  assign load_err          = (state == ERR);
  assign word_cnt          = wordCnt;

endmodule

// File: tb/tb_mips_imem_loader.sv
// tb_mips_imem_loader
//   Streams directed and random images into mips_imem_loader and compares
//   the resulting imem writes and status outputs with a stream-parsing
//   reference model. Inputs change on the falling edge, outputs are
//   sampled on the falling edge.
module tb_mips_imem_loader;

  localparam int Depth    = 256;
  localparam int BaseAddr = 0;
  localparam int AddrW    = 32;

  typedef logic [7:0] byteQ_t[$];

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        reload = 1'b0;
  logic        coreHold;
  logic        loadDone;
  logic        loadErr;
  logic [31:0] wordCnt;

  mips_imem_loader_if #(.ADDR_W(AddrW)) bus ();

  mips_imem_loader #(
    .IMEM_DEPTH (Depth),
    .BASE_ADDR  (BaseAddr),
    .ADDR_W     (AddrW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .reload    (reload),
    .core_hold (coreHold),
    .load_done (loadDone),
    .load_err  (loadErr),
    .word_cnt  (wordCnt)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic [63:0] wrLog[$];
  int          rdPtr = 0;
  int          acceptCnt = 0;
  int          overlapCnt = 0;
  int          doublePulse = 0;
  logic        prevWr = 1'b0;

  logic [63:0] expQ[$];
  logic [31:0] expN;
  bit          expErr;

  // Count bytes the DUT takes; ready still shows its pre-edge value here.
  always @(posedge clk) begin
    if (bus.byte_in_valid && bus.byte_in_ready) acceptCnt++;
  end

  // Record every write, and note any write that overlaps a ready cycle,
  // a released core, or a previous write cycle.
  always @(negedge clk) begin
    if (bus.imem_wr_en) begin
      wrLog.push_back({bus.imem_wr_addr, bus.imem_wr_data});
      if (bus.byte_in_ready || !coreHold) overlapCnt++;
      if (prevWr) doublePulse++;
    end
    prevWr = bus.imem_wr_en;
  end

  // Reference model: parse the stream as header + big-endian words.
  function automatic void runModel(input byteQ_t s);
    expQ.delete();
    expN   = {s[0], s[1], s[2], s[3]};
    expErr = (expN > 32'(Depth));
    if (!expErr) begin
      for (int i = 0; i < int'(expN); i++) begin
        logic [31:0] a;
        a = 32'(BaseAddr) + 32'(4 * i);
        expQ.push_back({a, s[4+4*i], s[5+4*i], s[6+4*i], s[7+4*i]});
      end
    end
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic applyReset();
    rst = 1'b0;
    reload = 1'b0;
    bus.byte_in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  // One byte with a random idle gap; valid stays high while ready is low.
  task automatic sendByte(input logic [7:0] b, input int maxGap);
    int gap;
    int waitCnt;
    gap = $urandom_range(0, maxGap);
    bus.byte_in_valid = 1'b0;
    repeat (gap) @(negedge clk);
    bus.byte_in_valid = 1'b1;
    bus.byte_in_data  = b;
    waitCnt = 0;
    while (!bus.byte_in_ready && waitCnt < 50) begin
      @(negedge clk);
      waitCnt++;
    end
    checkOutput("byteReady", 64'(bus.byte_in_ready), 64'(1));
    @(negedge clk);
    bus.byte_in_valid = 1'b0;
  endtask

  // Whole stream, checking header outcome and write latency on the way.
  task automatic applyStimulus(input byteQ_t s, input int maxGap);
    logic [31:0] hdrN;
    hdrN = {s[0], s[1], s[2], s[3]};
    for (int idx = 0; idx < s.size(); idx++) begin
      sendByte(s[idx], maxGap);
      if (idx == 3 && hdrN == 32'd0) checkOutput("zeroHdrDone", 64'(loadDone), 64'(1));
      if (idx == 3 && hdrN > 32'(Depth)) checkOutput("hdrErr", 64'(loadErr), 64'(1));
      if (idx >= 7 && (idx % 4) == 3 && hdrN != 32'd0 && hdrN <= 32'(Depth))
        checkOutput("wrLatency", 64'(bus.imem_wr_en), 64'(1));
    end
  endtask

  task automatic waitDone();
    int n;
    n = 0;
    while (!loadDone && n < 40) begin
      @(negedge clk);
      n++;
    end
    checkOutput("loadDone", 64'(loadDone), 64'(1));
  endtask

  task automatic compareWrites(input string tag);
    int got;
    got = wrLog.size() - rdPtr;
    checkOutput({tag, "Count"}, 64'(got), 64'(expQ.size()));
    for (int i = 0; i < got && i < expQ.size(); i++)
      checkOutput(tag, wrLog[rdPtr+i], expQ[i]);
    rdPtr = wrLog.size();
  endtask

  task automatic randomImage(input int n, output byteQ_t s);
    logic [31:0] w;
    s.delete();
    w = 32'(n);
    for (int k = 3; k >= 0; k--) s.push_back(w[8*k +: 8]);
    for (int i = 0; i < n; i++) begin
      w = $urandom;
      for (int k = 3; k >= 0; k--) s.push_back(w[8*k +: 8]);
    end
  endtask

  initial begin
    byteQ_t s;
    int     base;
    int     n;

    bus.byte_in_valid = 1'b0;
    bus.byte_in_data  = 8'h00;
    repeat (2) @(negedge clk);

    // Reset values
    checkOutput("rstReady",  64'(bus.byte_in_ready), 64'(0));
    checkOutput("rstWrEn",   64'(bus.imem_wr_en),    64'(0));
    checkOutput("rstAddr",   64'(bus.imem_wr_addr),  64'(BaseAddr));
    checkOutput("rstData",   64'(bus.imem_wr_data),  64'(0));
    checkOutput("rstHold",   64'(coreHold),          64'(1));
    checkOutput("rstDone",   64'(loadDone),          64'(0));
    checkOutput("rstErr",    64'(loadErr),           64'(0));
    checkOutput("rstWordCnt", 64'(wordCnt),          64'(0));
    rst = 1'b1;

    // Two-word image, back-to-back bytes
    s = '{8'h00, 8'h00, 8'h00, 8'h02, 8'h24, 8'h08, 8'h00, 8'h05, 8'h8C, 8'h09, 8'h00, 8'h04};
    runModel(s);
    checkOutput("t1ModelW0", expQ[0], {32'h0, 32'h24080005});
    base = acceptCnt;
    applyStimulus(s, 0);
    waitDone();
    compareWrites("t1Write");
    checkOutput("t1Hold",    64'(coreHold), 64'(0));
    checkOutput("t1WordCnt", 64'(wordCnt),  64'(2));
    checkOutput("t1Accept",  64'(acceptCnt - base), 64'(12));

    // Zero-length image
    applyReset();
    s = '{8'h00, 8'h00, 8'h00, 8'h00};
    runModel(s);
    applyStimulus(s, 0);
    checkOutput("t2Hold", 64'(coreHold), 64'(0));
    compareWrites("t2Write");

    // Oversized header -> sticky error, no bytes taken, reload ignored
    applyReset();
    s = '{8'h00, 8'h00, 8'h01, 8'h01};
    runModel(s);
    base = acceptCnt;
    applyStimulus(s, 0);
    bus.byte_in_valid = 1'b1;
    bus.byte_in_data  = 8'h55;
    reload = 1'b1;
    repeat (8) @(negedge clk);
    reload = 1'b0;
    bus.byte_in_valid = 1'b0;
    checkOutput("t3Err",    64'(loadErr),           64'(expErr));
    checkOutput("t3Ready",  64'(bus.byte_in_ready), 64'(0));
    checkOutput("t3Hold",   64'(coreHold),          64'(1));
    checkOutput("t3Accept", 64'(acceptCnt - base),  64'(4));
    compareWrites("t3Write");
    applyReset();
    checkOutput("t3ErrClr", 64'(loadErr), 64'(0));

    // Same two-word image with random gaps
    s = '{8'h00, 8'h00, 8'h00, 8'h02, 8'h24, 8'h08, 8'h00, 8'h05, 8'h8C, 8'h09, 8'h00, 8'h04};
    runModel(s);
    base = acceptCnt;
    applyStimulus(s, 5);
    waitDone();
    compareWrites("t4Write");
    checkOutput("t4Accept", 64'(acceptCnt - base), 64'(12));

    // Random images
    for (int r = 0; r < 4; r++) begin
      applyReset();
      n = $urandom_range(1, 6);
      randomImage(n, s);
      runModel(s);
      applyStimulus(s, 3);
      waitDone();
      compareWrites("rndWrite");
      checkOutput("rndWordCnt", 64'(wordCnt), 64'(n));
    end

    // Reset in the middle of a word, then a clean one-word image
    applyReset();
    s = '{8'h00, 8'h00, 8'h00, 8'h01, 8'hAA, 8'hBB};
    applyStimulus(s, 0);
    applyReset();
    s = '{8'h00, 8'h00, 8'h00, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
    runModel(s);
    applyStimulus(s, 0);
    waitDone();
    compareWrites("t5Write");

    // Reload from DONE
    reload = 1'b1;
    @(negedge clk);
    reload = 1'b0;
    checkOutput("t6Hold",    64'(coreHold), 64'(1));
    checkOutput("t6Done",    64'(loadDone), 64'(0));
    checkOutput("t6WordCnt", 64'(wordCnt),  64'(0));
    s = '{8'h00, 8'h00, 8'h00, 8'h01, 8'h12, 8'h34, 8'h56, 8'h78};
    runModel(s);
    applyStimulus(s, 2);
    waitDone();
    compareWrites("t6Write");
    checkOutput("t6WordCntEnd", 64'(wordCnt),  64'(1));
    checkOutput("t6HoldEnd",    64'(coreHold), 64'(0));

    checkOutput("wrOverlap",   64'(overlapCnt),  64'(0));
    checkOutput("wrDouble",    64'(doublePulse), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
